// File: rtl/note_sequencer.sv
// note_sequencer
// Steps through a 16-entry programmable note table and drives the downstream
// frequency rate divider.
//
// For every step the sequencer holds the step's count value on count_up_to,
// releases the divider from reset (unless the step is a rest), and keeps the
// note sounding for (beats * TEMPO_TICKS) cycles. The last GAP_TICKS cycles of
// every step are silent so that repeated notes are audibly separated.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   start          begin playback from step 0 (level, ignored while busy)
//   stop           abort playback on the next edge (wins over start)
//   loop_en        wrap to step 0 after last_step instead of finishing
//   last_step      index of the final step, latched when start is accepted
//   step_we        table write enable (any state)
//   step_addr      table write address
//   step_wdata     [35:32] beats-1, [31:0] count value (0 = rest)
//   count_up_to    count value for the rate divider
//   divider_reset  1 holds the rate divider in reset (silence)
//   note_on        1 while a non-rest note is sounding
//   step_idx       current step index
//   busy           1 while playing a step (note or gap)
//   done           one-cycle pulse at the normal end of a non-looping run
module note_sequencer #(
    parameter int TEMPO_TICKS = 12500000,
    parameter int GAP_TICKS   = 1250000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [3:0]  last_step,
    input  logic        step_we,
    input  logic [3:0]  step_addr,
    input  logic [35:0] step_wdata,
    output logic [31:0] count_up_to,
    output logic        divider_reset,
    output logic        note_on,
    output logic [3:0]  step_idx,
    output logic        busy,
    output logic        done
);

    localparam int TW = (TEMPO_TICKS > 1) ? $clog2(TEMPO_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TEMPO_TICKS - 1);
    // Last tick of the final beat that still belongs to the audible part.
    localparam logic [TW-1:0] PLAY_LAST = TW'(TEMPO_TICKS - GAP_TICKS - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    // Note table: plain register array, not reset.
    logic [35:0] table_q [16];

    always_ff @(posedge clock) begin
        if (step_we) begin
            table_q[step_addr] <= step_wdata;
        end
    end

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    beat_q, beat_d;
    logic [3:0]    beats_m1_q, beats_m1_d;
    logic [3:0]    last_q, last_d;
    logic [3:0]    idx_q, idx_d;
    logic [31:0]   cup_q, cup_d;
    logic          dr_q, dr_d;
    logic          on_q, on_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          entry;
    logic [3:0]    entry_idx;
    logic [35:0]   entry_row;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        beat_d     = beat_q;
        beats_m1_d = beats_m1_q;
        last_d     = last_q;
        idx_d      = idx_q;
        cup_d      = cup_q;
        dr_d       = dr_q;
        on_d       = on_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        entry      = 1'b0;
        entry_idx  = 4'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    entry     = 1'b1;
                    entry_idx = 4'd0;
                    last_d    = last_step;
                end
            end
            PLAY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    beat_d = beat_q + 4'd1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
                if (beat_q == beats_m1_q && tick_q == PLAY_LAST) begin
                    state_d = GAP;
                    dr_d    = 1'b1;
                    on_d    = 1'b0;
                end
            end
            GAP: begin
                // The gap never crosses a beat boundary: it ends on the last
                // tick of the final beat.
                if (tick_q == TICK_LAST) begin
                    if (idx_q != last_q) begin
                        entry     = 1'b1;
                        entry_idx = idx_q + 4'd1;
                    end else if (loop_en) begin
                        entry     = 1'b1;
                        entry_idx = 4'd0;
                    end else begin
                        // Normal end: step_idx keeps the final step.
                        state_d = IDLE;
                        cup_d   = '0;
                        dr_d    = 1'b1;
                        on_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Step entry latches the table row as it was before any write on
        // this same edge.
        entry_row = table_q[entry_idx];
        if (entry) begin
            state_d    = PLAY;
            idx_d      = entry_idx;
            tick_d     = '0;
            beat_d     = 4'd0;
            beats_m1_d = entry_row[35:32];
            cup_d      = entry_row[31:0];
            dr_d       = (entry_row[31:0] == 32'd0);
            on_d       = (entry_row[31:0] != 32'd0);
            busy_d     = 1'b1;
        end

        if (stop) begin
            state_d = IDLE;
            tick_d  = '0;
            beat_d  = 4'd0;
            idx_d   = 4'd0;
            cup_d   = '0;
            dr_d    = 1'b1;
            on_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            beat_q     <= 4'd0;
            beats_m1_q <= 4'd0;
            last_q     <= 4'd0;
            idx_q      <= 4'd0;
            cup_q      <= '0;
            dr_q       <= 1'b1;
            on_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            beat_q     <= beat_d;
            beats_m1_q <= beats_m1_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            cup_q      <= cup_d;
            dr_q       <= dr_d;
            on_q       <= on_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign count_up_to   = cup_q;
    assign divider_reset = dr_q;
    assign note_on       = on_q;
    assign step_idx      = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream stage for the synthesizer's frequency rate divider.
- Steps through a 16-entry programmable note table. For each step it drives the divider's count_up_to value and its reset/gate, holding the note for a programmable number of beats.
- Inserts a fixed silent gap at the end of each step so repeated notes are audibly separated.
- Downstream pulse rate is clock/(count_up_to+1); the square-wave toggle after the divider yields clock/(2*(count_up_to+1)).

Parameters:
- TEMPO_TICKS, 12500000: clock cycles per beat; must be > GAP_TICKS.
- GAP_TICKS, 1250000: silent cycles at the end of every step; must be >= 1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin playback from step 0 (level sampled each clock)
- stop  in  1  abort playback, synchronous
- loop_en  in  1  when 1, wrap to step 0 after last_step instead of finishing
- last_step  in  4  index of final step; latched on accepted start
- step_we  in  1  table write enable
- step_addr  in  4  table write address
- step_wdata  in  36  [35:32] beats-1, [31:0] count value; count 0 = rest
- count_up_to  out  32  count value for the rate divider
- divider_reset  out  1  1 = hold rate divider in reset (silence)
- note_on  out  1  1 while a non-rest note is sounding
- step_idx  out  4  current step index
- busy  out  1  1 while in PLAY or GAP
- done  out  1  one-cycle pulse at normal end of a non-looping sequence

Behaviour:
- Async reset: state IDLE, all counters 0, latched last_step = 0. Outputs: count_up_to=0, divider_reset=1, note_on=0, step_idx=0, busy=0, done=0. Table contents are not reset.
- Table: 16x36 register array. A write occurs on the clock edge when step_we=1, in any state. Step fields are latched into working registers at step entry, so a write to the playing step affects only its next entry.
- States: IDLE, PLAY, GAP.
- IDLE -> PLAY on the edge where start=1 and stop=0:
  - Latch last_step and step 0 fields; step_idx=0; tick and beat counters cleared.
  - busy=1 from that edge on.
- Step length is exactly (beats)*TEMPO_TICKS cycles, where beats = field+1 (range 1..16).
  - PLAY covers the first length-GAP_TICKS cycles of the step.
  - GAP covers the final GAP_TICKS cycles of the step.
- Counting: tick_cnt runs 0..TEMPO_TICKS-1 and wraps, incrementing beat_cnt.
  - PLAY -> GAP when beat_cnt = beats-1 and tick_cnt = TEMPO_TICKS-GAP_TICKS-1.
  - GAP ends when tick_cnt = TEMPO_TICKS-1.
- In PLAY with count != 0: count_up_to = latched count, divider_reset=0, note_on=1.
- In PLAY with count = 0 (rest): count_up_to=0, divider_reset=1, note_on=0. Timing is unchanged.
- In GAP: divider_reset=1, note_on=0, count_up_to holds its value.
- End of GAP, step_idx != last_step: next edge enters PLAY with step_idx+1; counters cleared, fields latched.
- End of GAP, step_idx = last_step:
  - loop_en=1: wrap to step 0 in PLAY, no done pulse.
  - loop_en=0: enter IDLE. Outputs take reset values, except step_idx, which holds its last value. done=1 for exactly that one cycle.
  - loop_en is sampled at this decision edge.
- stop=1 in any state: next edge forces IDLE with reset-value outputs, no done. stop beats start in the same cycle.
- start while busy is ignored.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
All scenarios use TEMPO_TICKS=10 and GAP_TICKS=2. "Edge N" counts from the start edge (edge 0).
- Reset mid-playback:
  - Stimulus: assert reset asynchronously during PLAY.
  - Response: outputs go to reset values immediately (0/1/0/0/0/0) without waiting for a clock edge; state is IDLE after release.
- Basic two-step sequence:
  - Stimulus: step0 = {beats-1=1, count=5}, step1 = {0, 0}, last_step=1, loop_en=0, start pulse at edge 0.
  - Step 0: count_up_to=5 and note_on=1 for 18 cycles, then note_on=0 and divider_reset=1 for 2 cycles.
  - Step 1: step_idx=1 from edge 20 with 10 silent cycles.
  - Finish: busy=0 and done=1 for one cycle after edge 30.
- Looping:
  - Stimulus: same table with loop_en=1.
  - Response: step_idx returns to 0 after edge 30; done never pulses; pattern repeats with a 30-cycle period.
- Stop and start interactions:
  - stop during step 0 PLAY: IDLE next edge, divider_reset=1, done=0.
  - start with stop in the same cycle: remains IDLE.
  - start asserted while busy: ignored.
- Live table write:
  - Stimulus: with loop_en=1, write step 0 count=9 during step 0.
  - Response: current pass keeps 5; the next pass at step 0 shows 9.
- Full-table boundary:
  - Stimulus: last_step=15, all beats-1=15.
  - Response: each step lasts 160 cycles; step_idx reaches 15; done pulses after edge 2560.
